seg_dynamic_scan: RTL and testbench

Downstream display stage for the six-digit eight-segment (7 + dp) module. Consumes the binary value, decimal-point mask, sign and enable produced by the data source stage. Converts the value to BCD with a sequential double-dabble engine, applies leading-zero blanking and sign placement, and time-multiplexes the six digits onto shared segment lines. All outputs are registered.

---
 rtl/seg_dynamic_scan.sv | 215 +++++++++++++++++++++
 tb/tb_seg_dynamic_scan.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_dynamic_scan.sv
// Six-digit multiplexed seven-segment driver. Each frame the input value is
// snapshotted, converted to BCD by a serial double-dabble engine, saturated,
// and loaded atomically into display registers. Digits are then scanned with
// leading-zero blanking and a leading minus sign. All outputs are registered.
module seg_dynamic_scan #(
  parameter logic [15:0] CNT_SCAN = 16'd49_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [19:0] data,
  input  logic [5:0]  point,
  input  logic        sign,
  input  logic        seg_en,
  output logic [5:0]  sel,
  output logic [7:0]  seg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } conv_state_t;

  // Active-low segment pattern (g..a) for one decimal digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  // ---------------------------------------------------------------- scan
  logic [15:0] scan_cnt;
  logic [2:0]  digit_idx;
  logic        scan_wrap;
  logic        frame_start;

  assign scan_wrap   = (scan_cnt == CNT_SCAN);
  assign frame_start = scan_wrap && (digit_idx == 3'd5);

  // Dwell counter and digit index; the index advances once per dwell.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      scan_cnt  <= 16'd0;
      digit_idx <= 3'd0;
    end else if (scan_wrap) begin
      scan_cnt  <= 16'd0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      scan_cnt  <= scan_cnt + 16'd1;
    end
  end

  // ----------------------------------------------------------- converter
  conv_state_t state, state_next;
  logic [19:0] shift_reg;
  logic [4:0]  bit_cnt;
  logic [27:0] bcd;          // seven nibbles; the top one only feeds saturation
  logic [23:0] bcd_adj;
  logic [23:0] bcd_sat;
  logic [5:0]  snap_point;
  logic        snap_sign;

  // Converter state register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_next;
  end

  // Converter next-state: one frame start kicks off 20 shifts and one load.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_start) state_next = SHIFT;
      SHIFT:   if (bit_cnt == 5'd19) state_next = LOAD;
      LOAD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Add-3 correction on the six low nibbles. The seventh digit never exceeds
  // 1 for a 20-bit input, so it never needs correcting.
  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd[gi*4 +: 4] >= 4'd5) ?
                                  bcd[gi*4 +: 4] + 4'd3 : bcd[gi*4 +: 4];
    end
  endgenerate

  // Snapshot on frame start, then shift one data bit into the BCD word per cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      shift_reg  <= 20'd0;
      bit_cnt    <= 5'd0;
      bcd        <= 28'd0;
      snap_point <= 6'd0;
      snap_sign  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (frame_start) begin
            shift_reg  <= data;
            snap_point <= point;
            snap_sign  <= sign;
            bcd        <= 28'd0;
            bit_cnt    <= 5'd0;
          end
        end
        SHIFT: begin
          bcd       <= {bcd[26:24], bcd_adj, shift_reg[19]};
          shift_reg <= {shift_reg[18:0], 1'b0};
          bit_cnt   <= bit_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Clamp to the largest value that fits, leaving room for '-' when negative.
  always_comb begin
    bcd_sat = bcd[23:0];
    if (!snap_sign && (bcd[27:24] != 4'd0))
      bcd_sat = 24'h999999;
    else if (snap_sign && ((bcd[27:24] != 4'd0) || (bcd[23:20] != 4'd0)))
      bcd_sat = 24'h099999;
  end

  // ------------------------------------------------------ display regs
  logic [23:0] disp_bcd;
  logic [5:0]  disp_point;
  logic        disp_sign;
  logic        disp_valid;

  // Atomic load of a fully converted value; nothing is shown before the first one.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      disp_bcd   <= 24'd0;
      disp_point <= 6'd0;
      disp_sign  <= 1'b0;
      disp_valid <= 1'b0;
    end else if (state == LOAD) begin
      disp_bcd   <= bcd_sat;
      disp_point <= snap_point;
      disp_sign  <= snap_sign;
      disp_valid <= 1'b1;
    end
  end

  // ---------------------------------------------------- digit decoding
  // zero_above[i]: digits i..5 are all zero and carry no decimal point.
  logic [6:1]  zero_above;
  logic [5:0]  blank;
  logic [5:0]  minus;
  logic [47:0] digit_codes;
  logic [7:0]  cur_code;

  assign zero_above[6] = 1'b1;

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_digit
      if (gi == 0) begin : g_lsd
        assign blank[gi] = 1'b0;
        assign minus[gi] = 1'b0;
      end else begin : g_upper
        assign zero_above[gi] = zero_above[gi+1] &&
                                (disp_bcd[gi*4 +: 4] == 4'd0) && !disp_point[gi];
        assign blank[gi] = zero_above[gi];
        // Blanking is monotone, so the blank/shown boundary is the sign slot.
        assign minus[gi] = disp_sign && blank[gi] && !blank[gi-1];
      end
      assign digit_codes[gi*8 +: 8] =
        minus[gi] ? 8'hBF :
        blank[gi] ? 8'hFF :
        {~disp_point[gi], seg_decode(disp_bcd[gi*4 +: 4])};
    end
  endgenerate

  // Pick the code of the digit currently being scanned.
  always_comb begin
    cur_code = 8'hFF;
    case (digit_idx)
      3'd0:    cur_code = digit_codes[7:0];
      3'd1:    cur_code = digit_codes[15:8];
      3'd2:    cur_code = digit_codes[23:16];
      3'd3:    cur_code = digit_codes[31:24];
      3'd4:    cur_code = digit_codes[39:32];
      3'd5:    cur_code = digit_codes[47:40];
      default: cur_code = 8'hFF;
    endcase
  end

  // Output register: blank while disabled or before the first load.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel <= 6'b111111;
      seg <= 8'hFF;
    end else if (!seg_en || !disp_valid) begin
      sel <= 6'b111111;
      seg <= 8'hFF;
    end else begin
      sel <= ~(6'b000001 << digit_idx);
      seg <= cur_code;
    end
  end

endmodule

// File: tb/tb_seg_dynamic_scan.sv
// Bench for seg_dynamic_scan: a decimal-arithmetic model predicts sel/seg on
// every cycle, and directed cases pin the visible digit codes to literals.
module tb_seg_dynamic_scan;

  localparam int C  = 24;
  localparam int DW = C + 1;
  localparam int F  = 6 * DW;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] data = 20'd0;
  logic [5:0]  point = 6'd0;
  logic        sign = 1'b0;
  logic        seg_en = 1'b1;
  logic [5:0]  sel;
  logic [7:0]  seg;

  int   vectors = 0;
  int   miscompares = 0;
  logic check_on = 1'b0;

  always #5 clk = ~clk;

  seg_dynamic_scan #(.CNT_SCAN(16'd24)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .data    (data),
    .point   (point),
    .sign    (sign),
    .seg_en  (seg_en),
    .sel     (sel),
    .seg     (seg)
  );

  function automatic logic [7:0] dig_code(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected code of each digit (digit i in bits [8i+7:8i]) for a snapshot.
  function automatic logic [47:0] expect_codes(input logic [19:0] val,
                                               input logic [5:0] p,
                                               input logic s);
    int v, lead, pw;
    int dd[6];
    logic [47:0] r;
    v = int'(val);
    if (!s && v > 999999) v = 999999;
    if (s && v > 99999)   v = 99999;
    pw = 1;
    for (int i = 0; i < 6; i++) begin
      dd[i] = (v / pw) % 10;
      pw = pw * 10;
    end
    lead = 0;
    for (int i = 0; i < 6; i++)
      if (dd[i] != 0 || p[i]) lead = i;
    r = '1;
    for (int i = 0; i < 6; i++) begin
      if (i <= lead)
        r[i*8 +: 8] = dig_code(dd[i]) & (p[i] ? 8'h7F : 8'hFF);
      else if (s && i == lead + 1)
        r[i*8 +: 8] = 8'hBF;
      else
        r[i*8 +: 8] = 8'hFF;
    end
    return r;
  endfunction

  // Reference model: m_n counts clock edges since reset release; digit
  // position, frame starts and the conversion load time follow from it.
  int          m_n;
  int          m_load_n;
  logic        m_valid;
  logic [47:0] m_disp;
  logic [47:0] m_pend;
  logic [5:0]  exp_sel;
  logic [7:0]  exp_seg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_n      <= 0;
      m_load_n <= -1;
      m_valid  <= 1'b0;
      m_disp   <= '0;
      m_pend   <= '0;
      exp_sel  <= 6'h3F;
      exp_seg  <= 8'hFF;
    end else begin
      if (seg_en && m_valid) begin
        exp_sel <= ~(6'b000001 << ((m_n / DW) % 6));
        exp_seg <= m_disp[((m_n / DW) % 6) * 8 +: 8];
      end else begin
        exp_sel <= 6'h3F;
        exp_seg <= 8'hFF;
      end
      if (m_n == m_load_n) begin
        m_disp  <= m_pend;
        m_valid <= 1'b1;
      end
      if (m_n % F == F - 1) begin
        m_pend   <= expect_codes(data, point, sign);
        m_load_n <= m_n + 21;
      end
      m_n <= m_n + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (check_on) begin
        vectors++;
        if (sel !== exp_sel || seg !== exp_seg) begin
          miscompares++;
          $display("FAIL cycle n=%0d: sel=%h seg=%h, expected sel=%h seg=%h",
                   m_n, sel, seg, exp_sel, exp_seg);
        end
      end
    end
  end

  // Walk digits 0..5 and compare each shown code against a literal.
  task automatic check_digits(input logic [47:0] exp, input string name);
    logic [5:0] want;
    logic       found;
    for (int i = 0; i < 6; i++) begin
      want  = ~(6'b000001 << i);
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
        @(negedge clk);
        if (sel === want) found = 1'b1;
      end
      vectors++;
      if (!found) begin
        miscompares++;
        $display("FAIL %s digit %0d: select %h never seen, last sel=%h", name, i, want, sel);
      end else if (seg !== exp[i*8 +: 8]) begin
        miscompares++;
        $display("FAIL %s digit %0d: seg=%h, expected %h", name, i, seg, exp[i*8 +: 8]);
      end
    end
    $display("case %s: digit codes checked", name);
  endtask

  task automatic run_case(input logic [19:0] v, input logic [5:0] p, input logic s,
                          input logic [47:0] exp, input string name);
    @(negedge clk);
    data  = v;
    point = p;
    sign  = s;
    repeat (2 * F + 10) @(negedge clk);
    check_digits(exp, name);
  endtask

  task automatic expect_blank(input string name);
    vectors++;
    if (sel !== 6'h3F || seg !== 8'hFF) begin
      miscompares++;
      $display("FAIL %s: sel=%h seg=%h, expected sel=3f seg=ff", name, sel, seg);
    end
    $display("case %s: blank outputs checked", name);
  endtask

  task automatic wait_frame_pos(input int pos);
    int k;
    k = 0;
    while ((m_n % F) != pos && k < 2 * F) begin
      @(negedge clk);
      k++;
    end
    vectors++;
    if ((m_n % F) != pos) begin
      miscompares++;
      $display("FAIL frame_sync: position %0d, expected %0d", m_n % F, pos);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_on = 1'b1;
    expect_blank("reset_state");
    rst = 1'b0;

    run_case(20'd123456, 6'd0, 1'b0, {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82}, "d123456");
    run_case(20'd42, 6'd0, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h99, 8'hA4}, "d42");
    run_case(20'd42, 6'b000100, 1'b0, {8'hFF, 8'hFF, 8'hFF, 8'h40, 8'h99, 8'hA4}, "d42_dp2");
    run_case(20'd7, 6'd0, 1'b1, {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hF8}, "neg7");
    run_case(20'd1048575, 6'd0, 1'b0, {6{8'h90}}, "sat_pos");
    run_case(20'd1048575, 6'd0, 1'b1, {8'hBF, {5{8'h90}}}, "sat_neg");
    run_case(20'd0, 6'd0, 1'b0, {{5{8'hFF}}, 8'hC0}, "zero");

    // Input change while the converter is shifting must not reach the display.
    run_case(20'd5, 6'd0, 1'b0, {{5{8'hFF}}, 8'h92}, "hold5_pre");
    wait_frame_pos(0);
    repeat (5) @(negedge clk);
    data = 20'd6;
    check_digits({{5{8'hFF}}, 8'h92}, "hold5_midshift");
    repeat (F) @(negedge clk);
    check_digits({{5{8'hFF}}, 8'h82}, "show6");

    // Disable blanks on the next cycle; scanning keeps running underneath.
    @(negedge clk);
    seg_en = 1'b0;
    @(negedge clk);
    expect_blank("seg_en_off");
    repeat (37) @(negedge clk);
    seg_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset in the middle of a conversion blanks at once and stays blank
    // until the first load after release.
    wait_frame_pos(3);
    #2 rst = 1'b1;
    #1 expect_blank("async_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (75) @(negedge clk);
    expect_blank("blank_after_reset");

    // Randomized inputs, changed at arbitrary cycles including mid-conversion.
    for (int f = 0; f < 24; f++) begin
      for (int k = 0; k < F; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 39) == 0) begin
          case ($urandom_range(0, 3))
            0:       data = 20'($urandom_range(0, 99));
            1:       data = 20'($urandom_range(0, 99999));
            2:       data = 20'($urandom_range(0, 999999));
            default: data = 20'($urandom);
          endcase
          point = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
          sign  = 1'($urandom);
        end
        if ($urandom_range(0, 63) == 0)
          seg_en = ($urandom_range(0, 7) != 0);
      end
      $display("random frame %0d: data=%0d point=%b sign=%0d seg_en=%0d",
               f, data, point, sign, seg_en);
    end

    @(negedge clk);
    check_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
